// File: rtl/ws2812_frame_tx.sv
// WS2812-class serial transmitter for a single-lit-pixel frame.
// A start captures the lit position, sends NUM_LEDS GRB words MSB first,
// holds the line low for the latch gap and pulses done for one cycle.
module ws2812_frame_tx #(
    parameter int          NUM_LEDS     = 51,
    parameter int          T0H          = 40,
    parameter int          T0L          = 85,
    parameter int          T1H          = 80,
    parameter int          T1L          = 45,
    parameter int          RESET_CYCLES = 5000,
    parameter logic [23:0] ON_COLOR     = 24'h0000FF,
    parameter logic [23:0] OFF_COLOR    = 24'h000000
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         start,
    input  logic [$clog2(NUM_LEDS):0]    position,
    output logic                         busy,
    output logic                         done,
    output logic                         signal_out
);

    localparam int PW    = $clog2(NUM_LEDS) + 1;
    localparam int MAX_A = (T0H > T0L) ? T0H : T0L;
    localparam int MAX_B = (T1H > T1L) ? T1H : T1L;
    localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAXT  = (MAX_C > RESET_CYCLES) ? MAX_C : RESET_CYCLES;
    localparam int CW    = $clog2(MAXT + 1);

    // Phase lengths stored as terminal counts (length - 1).
    localparam logic [CW-1:0] T0H_M1   = CW'(T0H - 1);
    localparam logic [CW-1:0] T0L_M1   = CW'(T0L - 1);
    localparam logic [CW-1:0] T1H_M1   = CW'(T1H - 1);
    localparam logic [CW-1:0] T1L_M1   = CW'(T1L - 1);
    localparam logic [CW-1:0] GAP_M1   = CW'(RESET_CYCLES - 1);
    localparam logic [PW-1:0] LAST_PIX = PW'(NUM_LEDS - 1);

    typedef enum logic [1:0] {IDLE, BIT_HIGH, BIT_LOW, RESET_GAP} state_t;

    state_t          state, state_d;
    logic [CW-1:0]   cnt;
    logic [4:0]      bit_idx;
    logic [PW-1:0]   pixel_idx;
    logic [PW-1:0]   pos_q;
    logic [23:0]     word_q;
    logic            cur_bit;
    logic [CW-1:0]   t_hi, t_lo;
    logic            accept, adv_bit, adv_pix, done_d;

    assign cur_bit = word_q[bit_idx];
    assign t_hi    = cur_bit ? T1H_M1 : T0H_M1;
    assign t_lo    = cur_bit ? T1L_M1 : T0L_M1;

    // State register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_d;
    end

    // Next-state logic and per-cycle datapath controls.
    always_comb begin
        state_d = state;
        accept  = 1'b0;
        adv_bit = 1'b0;
        adv_pix = 1'b0;
        done_d  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = BIT_HIGH;
                end
            end
            BIT_HIGH: begin
                if (cnt == t_hi) state_d = BIT_LOW;
            end
            BIT_LOW: begin
                if (cnt == t_lo) begin
                    if (bit_idx != 5'd0) begin
                        adv_bit = 1'b1;
                        state_d = BIT_HIGH;
                    end else if (pixel_idx < LAST_PIX) begin
                        adv_pix = 1'b1;
                        state_d = BIT_HIGH;
                    end else begin
                        state_d = RESET_GAP;
                    end
                end
            end
            RESET_GAP: begin
                if (cnt == GAP_M1) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Phase counter, bit/pixel indices and the word being shifted out.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cnt       <= '0;
            bit_idx   <= '0;
            pixel_idx <= '0;
            pos_q     <= '0;
            word_q    <= '0;
        end else begin
            // Counter restarts on every phase change and rests at 0 in IDLE.
            if (state_d != state || state == IDLE) cnt <= '0;
            else                                   cnt <= cnt + CW'(1);
            if (accept) begin
                pos_q     <= position;
                pixel_idx <= '0;
                bit_idx   <= 5'd23;
                word_q    <= (position == PW'(0)) ? ON_COLOR : OFF_COLOR;
            end else if (adv_bit) begin
                bit_idx   <= bit_idx - 5'd1;
            end else if (adv_pix) begin
                pixel_idx <= pixel_idx + PW'(1);
                bit_idx   <= 5'd23;
                word_q    <= ((pixel_idx + PW'(1)) == pos_q) ? ON_COLOR : OFF_COLOR;
            end
        end
    end

    // Registered outputs derived from the upcoming state.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            signal_out <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            signal_out <= (state_d == BIT_HIGH);
            busy       <= (state_d != IDLE);
            done       <= done_d;
        end
    end

endmodule

// File: tb/tb_ws2812_frame_tx.sv
// Bench for ws2812_frame_tx: builds the expected line waveform of each frame
// from the pixel/bit rules and compares signal_out, busy and done per cycle.
module tb_ws2812_frame_tx;

    localparam int          NL   = 3;
    localparam int          P0H  = 2;
    localparam int          P0L  = 3;
    localparam int          P1H  = 4;
    localparam int          P1L  = 1;
    localparam int          GAP  = 10;
    localparam logic [23:0] ONC  = 24'h800001;
    localparam logic [23:0] OFFC = 24'h000000;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic       start  = 1'b0;
    logic [2:0] position = '0;
    logic       busy, done, signal_out;

    int n_chk  = 0;
    int n_fail = 0;

    ws2812_frame_tx #(
        .NUM_LEDS(NL), .T0H(P0H), .T0L(P0L), .T1H(P1H), .T1L(P1L),
        .RESET_CYCLES(GAP), .ON_COLOR(ONC), .OFF_COLOR(OFFC)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .start(start), .position(position),
        .busy(busy), .done(done), .signal_out(signal_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // mode 0: plain start pulse; 1: start/position perturbed while busy;
    // 2: start held high. skip_issue: start was already sampled during the
    // previous done cycle. abort_k > 0: assert reset asynchronously at that cycle.
    task automatic check_frame(input int pos, input int mode, input bit skip_issue, input int abort_k);
        bit          exp_q[$];
        logic [23:0] w;
        int          len;
        exp_q.delete();
        for (int p = 0; p < NL; p++) begin
            w = (p == pos) ? ONC : OFFC;
            for (int b = 23; b >= 0; b--) begin
                if (w[b]) begin
                    repeat (P1H) exp_q.push_back(1'b1);
                    repeat (P1L) exp_q.push_back(1'b0);
                end else begin
                    repeat (P0H) exp_q.push_back(1'b1);
                    repeat (P0L) exp_q.push_back(1'b0);
                end
            end
        end
        repeat (GAP) exp_q.push_back(1'b0);
        len = exp_q.size();
        if (!skip_issue) begin
            @(negedge clk_in);
            start    = 1'b1;
            position = 3'(pos);
        end
        for (int k = 1; k <= len + 1; k++) begin
            @(negedge clk_in);
            if (k == 1 && mode != 2) start = 1'b0;
            if (mode == 1) begin
                if (k < len - 5) begin
                    start    = 1'($urandom);
                    position = 3'($urandom);
                end else begin
                    start = 1'b0;
                end
            end
            if (k <= len) begin
                chk("sig",  32'(signal_out), 32'(exp_q[k-1]));
                chk("busy", 32'(busy), 32'd1);
                chk("done", 32'(done), 32'd0);
            end else begin
                chk("sig_end",  32'(signal_out), 32'd0);
                chk("busy_end", 32'(busy), 32'd0);
                chk("done_end", 32'(done), 32'd1);
            end
            if (k == abort_k) begin
                #2 rst_in = 1'b1;
                #1;
                chk("rst_sig",  32'(signal_out), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
                return;
            end
        end
    endtask

    task automatic check_idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk_in);
            chk("idle_sig",  32'(signal_out), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_done", 32'(done), 32'd0);
        end
    endtask

    initial begin
        int p;
        // Reset held while start toggles.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_in);
            start = ~start;
            chk("rst_hold_sig",  32'(signal_out), 32'd0);
            chk("rst_hold_busy", 32'(busy), 32'd0);
            chk("rst_hold_done", 32'(done), 32'd0);
        end
        @(negedge clk_in);
        start  = 1'b0;
        rst_in = 1'b0;
        check_idle(3);

        // Directed frames: in-range and out-of-range position.
        check_frame(1, 0, 1'b0, 0);
        check_idle(2);
        check_frame(5, 0, 1'b0, 0);
        check_idle(2);

        // Randomized positions, some with perturbation while busy.
        for (int r = 0; r < 4; r++) begin
            p = int'($urandom_range(0, 4));
            check_frame(p, int'($urandom_range(0, 1)), 1'b0, 0);
            check_idle(1);
        end
        check_frame(0, 1, 1'b0, 0);
        check_idle(1);

        // Start held high: frames run back to back off the done cycle.
        p = int'($urandom_range(0, 2));
        check_frame(p, 2, 1'b0, 0);
        check_frame(p, 2, 1'b1, 0);
        check_frame(p, 2, 1'b1, 0);
        start = 1'b0;
        check_idle(2);

        // Asynchronous reset during pixel 1, bit 10 (high phase).
        check_frame(1, 0, 1'b0, 24 * 5 + 13 * 5 + 1);
        @(negedge clk_in);
        chk("rst_mid_sig",  32'(signal_out), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        rst_in = 1'b0;
        check_idle(2);
        check_frame(int'($urandom_range(0, 4)), 0, 1'b0, 0);
        check_idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ws2812_frame_tx.md
Name: ws2812_frame_tx

Overview:
- Serial WS2812-class LED strip transmitter for a one-lit-LED frame.
- Sits directly downstream of the position sequencer. On `start` it captures `position`, emits one full GRB frame for `NUM_LEDS` pixels, then holds the line low for the latch/reset gap.
- Only pixel `position` gets `ON_COLOR`; every other pixel gets `OFF_COLOR`.
- Reports completion with a one-cycle `done` pulse that the sequencer consumes before starting its latch delay.

Parameters:
- NUM_LEDS, 51, number of pixels on the strip (at least 1).
- T0H, 40, clk_in cycles high for a 0 bit (0.40 us at 100 MHz).
- T0L, 85, clk_in cycles low for a 0 bit.
- T1H, 80, clk_in cycles high for a 1 bit.
- T1L, 45, clk_in cycles low for a 1 bit.
- RESET_CYCLES, 5000, low cycles after the last bit (50 us latch gap).
- ON_COLOR, 24'h0000FF, GRB word for the lit pixel.
- OFF_COLOR, 24'h000000, GRB word for all other pixels.

Ports:
- clk_in  input  1  system clock (100 MHz).
- rst_in  input  1  reset, asynchronous, active-high.
- start  input  1  frame request; accepted only while busy=0.
- position  input  $clog2(NUM_LEDS)+1  index of lit pixel; sampled on accepted start.
- busy  output  1  high from the cycle after accept until the done cycle.
- done  output  1  one-cycle pulse at end of the reset gap.
- signal_out  output  1  serial data line to strip DIN.

Behaviour:
- Interface: one clock, clk_in; rst_in is asynchronous active-high. Asserting rst_in immediately forces state=IDLE, signal_out=0, busy=0, done=0, and clears all counters and the latched position. This applies mid-frame too: the line drops low at once and the partial frame is abandoned. The first start after release begins a fresh frame from pixel 0.
- States:
  - IDLE: signal_out=0, busy=0.
    - start=1 at edge t: latch position to pos_q, pixel_idx=0, bit_idx=23, load the pixel word, go to BIT_HIGH.
    - From t+1: busy=1, signal_out=1.
  - BIT_HIGH: signal_out=1.
    - Hold THI cycles, where THI = T1H if the current bit = 1, else T0H.
    - Then go to BIT_LOW.
  - BIT_LOW: signal_out=0.
    - Hold TLO cycles (T1L or T0L by the same rule).
    - Then advance:
      - bit_idx>0: bit_idx-1, go to BIT_HIGH.
      - bit_idx==0 and pixel_idx<NUM_LEDS-1: pixel_idx+1, bit_idx=23, reload word, go to BIT_HIGH.
      - Otherwise: go to RESET_GAP.
  - RESET_GAP: signal_out=0 for RESET_CYCLES cycles, then go to IDLE with done=1 and busy=0 for exactly that one cycle.
- Start timing:
  - A start present during the done cycle (state already IDLE) is accepted, so frames can run back to back with no gap beyond RESET_CYCLES.
  - start while busy=1 is ignored and not queued.
- Pixel word: ON_COLOR if pixel_idx==pos_q, else OFF_COLOR.
  - pos_q >= NUM_LEDS gives an all-OFF frame of normal length; no error.
  - Word is sent MSB first (G7..G0, R7..R0, B7..B0). Pixel 0 goes first.
- Frame length: start edge to done cycle = NUM_LEDS*Σ(bit times) + RESET_CYCLES + 1 cycles.
  - Each bit takes T0H+T0L or T1H+T1L cycles.
  - Changing position while busy has no effect on the frame in flight.
- Counters: the bit-time counter must hold max(T*H, T*L, RESET_CYCLES). There is no wrap-around at any supported parameter value.
- signal_out is registered; there is no combinational path from inputs to outputs.

Test Plan:
- Common parameters: NUM_LEDS=3, T0H=2, T0L=3, T1H=4, T1L=1, RESET_CYCLES=10, ON_COLOR=24'h800001, OFF_COLOR=0. Every bit takes 5 cycles.
- Reset: hold rst_in, toggle start → signal_out=0, busy=0, done=0 throughout. Deassert rst_in → still idle.
- position=1, start pulse at edge t:
  - busy rises at t+1.
  - Pixels 0 and 2: each 24 bits of 2-high/3-low.
  - Pixel 1: bit23=4H/1L, bits 22..1=2H/3L, bit0=4H/1L.
  - Then 10 low cycles, and done one cycle at t+371 (3*24*5+10+1).
- position=5 (out of range) → 72 bits all 2H/3L, done at t+371, no 4-cycle high pulse anywhere.
- start re-pulsed and position changed mid-frame → waveform identical to the unperturbed run, single done.
- start held high continuously → a second frame begins the cycle after done (signal_out=1 at done+1), done every 371 cycles.
- rst_in asserted asynchronously during pixel 1, bit 10 → signal_out=0 and busy=0 before the next clk edge. A new start after release → full frame from pixel 0, done at +371.
